ws2812_rx: RTL and testbench
============================

# ws2812_rx

Single-wire WS2812 NRZ stream receiver: the decoding end of the protocol that `ws2812_ctrl` drives on `dout`. It samples the line on `sys_clk`, measures each high pulse to classify it as a 0 or 1 bit, and assembles 24-bit GRB words. It reports each pixel with its index and flags the reset gap that ends a frame. It sits on the board loopback and self-check path, fed by the LED data line, so pattern and `data_cfg` output can be verified without a camera.

## Interface
- `BIT_THRESH`, default 28: high width in cycles at or above which a bit is 1.
- `MIN_HIGH`, default 5: high pulses shorter than this are glitches.
- `MAX_HIGH`, default 60: high longer than this is an error.
- `RESET_CYC`, default 2500: consecutive low cycles that end a frame (50 µs at 50 MHz).
- `PIXEL_MAX`, default 64: maximum pixels reported per frame.
- `sys_clk`  in  1  system clock, 50 MHz; the only clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  asynchronous WS2812 serial line.
- `pixel_data`  out  24  last complete pixel, first-received bit in [23] (G[23:16], R[15:8], B[7:0]).
- `pixel_idx`  out  7  index of `pixel_data` within the frame, from 0.
- `pixel_valid`  out  1  one-cycle strobe; `pixel_data` and `pixel_idx` are valid this cycle.
- `frame_done`  out  1  one-cycle strobe at the end-of-frame gap.
- `frame_len`  out  8  pixels reported in the frame just ended; valid with `frame_done`.
- `bit_err`  out  1  one-cycle strobe on a protocol error.

## Operation
- Input conditioning:
  - `din` passes through a 2-flop synchronizer (s1, s2) and a third register s3.
  - A rise is s2=1, s3=0. A fall is s2=0, s3=1.
- Counters:
  - `hcnt` is 8 bits and saturates at 255. It clears on a rise and increments each cycle while s2=1.
  - `lcnt` is 12 bits and saturates. It clears on a fall and increments each cycle while s2=0.
- States:
  - SYNC: reset state. All input is ignored. Go to LOW when `lcnt` reaches RESET_CYC. No `frame_done` is issued on this transition.
  - LOW: on a rise, go to HIGH. When `lcnt` reaches RESET_CYC and at least one bit was accepted since the last frame end, do the frame end (below); stay in LOW.
  - HIGH: on a fall, classify the pulse with width w = `hcnt`:
    - w < MIN_HIGH: discard the pulse; no bit, no error.
    - MIN_HIGH ≤ w < BIT_THRESH: bit 0.
    - BIT_THRESH ≤ w ≤ MAX_HIGH: bit 1.
    - Then go to LOW.
  - HIGH overflow: when `hcnt` reaches MAX_HIGH+1 while still high, pulse `bit_err`, clear the shift register and bit counter, and go to SYNC.
- Assembly:
  - Each accepted bit shifts into the LSB of a 24-bit register; a 5-bit counter counts bits 0..23.
  - On the 24th bit, if the pixel counter < PIXEL_MAX: load `pixel_data`, set `pixel_idx` to the counter, pulse `pixel_valid`, and increment the counter.
  - At PIXEL_MAX, further pixels are decoded but not reported, and the counter holds.
  - The bit counter wraps to 0.
- Frame end:
  - Set `frame_len` to the pixel counter and pulse `frame_done`.
  - If the bit counter ≠ 0, pulse `bit_err` in the same cycle and discard the partial pixel.
  - Clear the pixel counter, bit counter and accepted-bit flag.
- Reset, including mid-frame:
  - Outputs go to zero: `pixel_data`=0, `pixel_idx`=0, `pixel_valid`=0, `frame_done`=0, `frame_len`=0, `bit_err`=0.
  - State goes to SYNC and all counters clear.
  - Data already in flight is lost; decoding resumes only after a full RESET_CYC gap.

## Timing
- Every strobe is exactly one cycle. All outputs are registered.
- Latency: `pixel_valid` asserts 4 cycles after the 24th falling edge on `din` (2 synchronizer, 1 edge detect, 1 output register).
- `frame_done` asserts 3 + RESET_CYC cycles after the last falling edge on `din`.
- `pixel_data` and `frame_len` hold their values until the next strobe that loads them.
- Minimum supported bit period: MIN_HIGH high plus 2 low cycles.
- A 24th bit and a frame end never coincide: frame end requires RESET_CYC low cycles after the last fall.

## Test plan
- Pixel decode:
  - Stimulus: reset, 2500 low cycles, then one pixel 0xA53CF0 (bit 0 = 18 high / 44 low, bit 1 = 38 high / 24 low), then 2600 low cycles.
  - Response: one `pixel_valid` with `pixel_data`=0xA53CF0, `pixel_idx`=0, 4 cycles after the last fall. Then `frame_done` with `frame_len`=1 and no `bit_err`.
- Sync gating:
  - Stimulus: a pixel sent 100 cycles after reset release, before any gap.
  - Response: no `pixel_valid`, no `frame_done`. A pixel sent after a 2500-cycle gap decodes normally.
- Glitch and boundary widths:
  - Stimulus: a 3-cycle high inserted between bits; bits with high widths of exactly 5, 27, 28 and 60 cycles.
  - Response: the glitch is ignored. The bits decode as 0, 0, 1, 1. The pixel value is unaffected by the glitch.
- Stuck high:
  - Stimulus: hold `din` high for 70 cycles mid-pixel.
  - Response: `bit_err` pulses once. Following bits are ignored until a 2500-cycle low gap. The next pixel then decodes with `pixel_idx`=0.
- Partial pixel:
  - Stimulus: send 12 bits, then hold low 2600 cycles.
  - Response: `frame_done` and `bit_err` pulse in the same cycle, `frame_len`=0, no `pixel_valid`.
- Overflow and mid-frame reset:
  - Stimulus: send 65 pixels, then a gap.
  - Response: 64 `pixel_valid` strobes with `pixel_idx` 0..63, then `frame_done` with `frame_len`=64.
  - Stimulus: assert `sys_rst_n` low mid-frame.
  - Response: all outputs are 0 immediately, and the next frame decodes cleanly after a gap.

Source files
------------

// File: rtl/ws2812_rx_if.sv
// Decoded-pixel output bundle of the WS2812 receiver: the receiver drives it
// through the master modport, consumers read it through the slave modport.
interface ws2812_rx_if;
  logic [23:0] pixel_data;
  logic [6:0]  pixel_idx;
  logic        pixel_valid;
  logic        frame_done;
  logic [7:0]  frame_len;
  logic        bit_err;

  modport master (
    output pixel_data, pixel_idx, pixel_valid, frame_done, frame_len, bit_err
  );

  modport slave (
    input pixel_data, pixel_idx, pixel_valid, frame_done, frame_len, bit_err
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 NRZ line receiver: measures high pulses on din, assembles 24-bit GRB
// pixels, and reports pixels, end-of-frame gaps and protocol errors.
module ws2812_rx #(
  parameter int BIT_THRESH = 28,
  parameter int MIN_HIGH   = 5,
  parameter int MAX_HIGH   = 60,
  parameter int RESET_CYC  = 2500,
  parameter int PIXEL_MAX  = 64
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          din,
  ws2812_rx_if.master   rx
);

  localparam logic [7:0]  C_MIN    = 8'(MIN_HIGH);
  localparam logic [7:0]  C_THRESH = 8'(BIT_THRESH);
  localparam logic [7:0]  C_OVF    = 8'(MAX_HIGH + 1);
  localparam logic [11:0] C_RESET  = 12'(RESET_CYC);
  localparam logic [6:0]  C_PMAX   = 7'(PIXEL_MAX);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_LOW,
    ST_HIGH
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic [7:0]  r_hcnt;
  logic [11:0] r_lcnt;
  logic [23:0] r_shift;
  logic [4:0]  r_bitcnt;
  logic [6:0]  r_pixcnt;
  logic        r_acc;
  logic        r_word_done;

  logic [23:0] r_pixel_data;
  logic [6:0]  r_pixel_idx;
  logic        r_pixel_valid;
  logic        r_frame_done;
  logic [7:0]  r_frame_len;
  logic        r_bit_err;

  logic        w_rise;
  logic        w_fall;
  logic        w_bit_accept;
  logic        w_bit_val;
  logic        w_frame_end;
  logic        w_overflow;

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // The edge cycle itself is counted, so hcnt equals the high width at the fall.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hcnt <= '0;
      r_lcnt <= '0;
    end else begin
      if (w_rise)
        r_hcnt <= 8'd1;
      else if (r_s2 && (r_hcnt != 8'hFF))
        r_hcnt <= r_hcnt + 8'd1;

      if (w_fall)
        r_lcnt <= 12'd1;
      else if (!r_s2 && (r_lcnt != 12'hFFF))
        r_lcnt <= r_lcnt + 12'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_state <= ST_SYNC;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_bit_accept = 1'b0;
    w_bit_val    = 1'b0;
    w_frame_end  = 1'b0;
    w_overflow   = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (!r_s2 && (r_lcnt >= C_RESET))
          w_state_next = ST_LOW;
      end
      ST_LOW: begin
        if (w_rise)
          w_state_next = ST_HIGH;
        else if ((r_lcnt == C_RESET) && r_acc)
          w_frame_end = 1'b1;
      end
      ST_HIGH: begin
        if (r_hcnt >= C_OVF) begin
          w_overflow   = 1'b1;
          w_state_next = ST_SYNC;
        end else if (w_fall) begin
          w_state_next = ST_LOW;
          if (r_hcnt >= C_MIN) begin
            w_bit_accept = 1'b1;
            w_bit_val    = (r_hcnt >= C_THRESH);
          end
        end
      end
      default: w_state_next = ST_SYNC;
    endcase
  end

  // A stuck line also drops the frame's pixel count so decoding restarts at index 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shift       <= '0;
      r_bitcnt      <= '0;
      r_pixcnt      <= '0;
      r_acc         <= 1'b0;
      r_word_done   <= 1'b0;
      r_pixel_data  <= '0;
      r_pixel_idx   <= '0;
      r_pixel_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_len   <= '0;
      r_bit_err     <= 1'b0;
    end else begin
      r_pixel_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_bit_err     <= 1'b0;
      r_word_done   <= 1'b0;

      if (w_overflow) begin
        r_bit_err <= 1'b1;
        r_shift   <= '0;
        r_bitcnt  <= '0;
        r_pixcnt  <= '0;
        r_acc     <= 1'b0;
      end else if (w_bit_accept) begin
        r_shift <= {r_shift[22:0], w_bit_val};
        r_acc   <= 1'b1;
        if (r_bitcnt == 5'd23) begin
          r_bitcnt    <= '0;
          r_word_done <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + 5'd1;
        end
      end else if (w_frame_end) begin
        r_frame_len  <= {1'b0, r_pixcnt};
        r_frame_done <= 1'b1;
        if (r_bitcnt != 5'd0) begin
          r_bit_err <= 1'b1;
          r_shift   <= '0;
        end
        r_bitcnt <= '0;
        r_pixcnt <= '0;
        r_acc    <= 1'b0;
      end

      if (r_word_done && (r_pixcnt < C_PMAX)) begin
        r_pixel_data  <= r_shift;
        r_pixel_idx   <= r_pixcnt;
        r_pixel_valid <= 1'b1;
        r_pixcnt      <= r_pixcnt + 7'd1;
      end
    end
  end

  assign rx.pixel_data  = r_pixel_data;
  assign rx.pixel_idx   = r_pixel_idx;
  assign rx.pixel_valid = r_pixel_valid;
  assign rx.frame_done  = r_frame_done;
  assign rx.frame_len   = r_frame_len;
  assign rx.bit_err     = r_bit_err;

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: drives randomized WS2812 streams and
// compares every strobe, its cycle and its payload against a pulse-level model.
module tb_ws2812_rx;
  localparam int BIT_THRESH = 28;
  localparam int MIN_HIGH   = 5;
  localparam int MAX_HIGH   = 60;
  localparam int RESET_CYC  = 2500;
  localparam int PIXEL_MAX  = 64;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic din       = 1'b0;

  ws2812_rx_if rxIf();

  ws2812_rx #(
    .BIT_THRESH (BIT_THRESH),
    .MIN_HIGH   (MIN_HIGH),
    .MAX_HIGH   (MAX_HIGH),
    .RESET_CYC  (RESET_CYC),
    .PIXEL_MAX  (PIXEL_MAX)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (din),
    .rx        (rxIf)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    int          cyc;
    logic [23:0] data;
    logic [6:0]  idx;
  } pv_t;

  typedef struct {
    int          cyc;
    logic [7:0]  len;
  } fd_t;

  int  cyc = 0;
  pv_t actPv[$];
  pv_t expPv[$];
  fd_t actFd[$];
  fd_t expFd[$];
  int  actErr[$];
  int  expErr[$];

  int checks = 0;
  int errors = 0;

  // Line-level view of the receiver: what a frame should yield, in pulse terms.
  bit          synced;
  bit          accepted;
  int          bitsInWord;
  int          pixCount;
  int          lastFall;
  logic [23:0] word;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Capture every strobe with the cycle it was seen in.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (rxIf.pixel_valid) actPv.push_back('{cyc, rxIf.pixel_data, rxIf.pixel_idx});
      if (rxIf.frame_done)  actFd.push_back('{cyc, rxIf.frame_len});
      if (rxIf.bit_err)     actErr.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic level, input int n);
    din = level;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic modelClear();
    synced     = 1'b0;
    accepted   = 1'b0;
    bitsInWord = 0;
    pixCount   = 0;
    word       = '0;
  endtask

  // One high pulse of width hi followed by lo low cycles, with its expected effect.
  task automatic sendBit(input int hi, input int lo);
    int riseCyc;
    int fallCyc;
    riseCyc = cyc;
    applyStimulus(1'b1, hi);
    fallCyc = cyc;
    applyStimulus(1'b0, lo);
    lastFall = fallCyc;
    if (!synced) return;
    if (hi > MAX_HIGH) begin
      expErr.push_back(riseCyc + MAX_HIGH + 4);
      modelClear();
    end else if (hi >= MIN_HIGH) begin
      word     = {word[22:0], 1'(hi >= BIT_THRESH)};
      accepted = 1'b1;
      bitsInWord++;
      if (bitsInWord == 24) begin
        if (pixCount < PIXEL_MAX) begin
          expPv.push_back('{fallCyc + 4, word, 7'(pixCount)});
          pixCount++;
        end
        bitsInWord = 0;
      end
    end
  endtask

  task automatic sendGap(input int n);
    applyStimulus(1'b0, n);
    if (cyc - lastFall >= RESET_CYC + 8) begin
      if (!synced) begin
        synced = 1'b1;
      end else if (accepted) begin
        expFd.push_back('{lastFall + 3 + RESET_CYC, 8'(pixCount)});
        if (bitsInWord != 0) expErr.push_back(lastFall + 3 + RESET_CYC);
        pixCount   = 0;
        bitsInWord = 0;
        accepted   = 1'b0;
      end
    end
  endtask

  task automatic sendDataBit(input logic b, input bit fast);
    int hi;
    int lo;
    if (fast) begin
      hi = b ? int'($urandom_range(BIT_THRESH + 3, BIT_THRESH)) : int'($urandom_range(MIN_HIGH + 3, MIN_HIGH));
      lo = int'($urandom_range(4, 2));
    end else begin
      hi = b ? int'($urandom_range(MAX_HIGH, BIT_THRESH)) : int'($urandom_range(BIT_THRESH - 1, MIN_HIGH));
      lo = int'($urandom_range(20, 2));
    end
    sendBit(hi, lo);
  endtask

  task automatic sendBits(input logic [23:0] w, input int nBits, input bit fast, input int glitchPct);
    for (int i = nBits - 1; i >= 0; i--) begin
      if (int'($urandom_range(99, 0)) < glitchPct)
        sendBit(int'($urandom_range(MIN_HIGH - 1, 1)), int'($urandom_range(10, 2)));
      sendDataBit(w[i], fast);
    end
  endtask

  task automatic doReset();
    din       = 1'b0;
    sys_rst_n = 1'b0;
    #1;
  endtask

  task automatic releaseReset();
    repeat (3) begin
      @(posedge sys_clk);
      #1;
    end
    sys_rst_n = 1'b1;
    modelClear();
    lastFall = cyc;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "/pixel_data"},  64'(rxIf.pixel_data),  64'd0);
    checkOutput({tag, "/pixel_idx"},   64'(rxIf.pixel_idx),   64'd0);
    checkOutput({tag, "/pixel_valid"}, 64'(rxIf.pixel_valid), 64'd0);
    checkOutput({tag, "/frame_done"},  64'(rxIf.frame_done),  64'd0);
    checkOutput({tag, "/frame_len"},   64'(rxIf.frame_len),   64'd0);
    checkOutput({tag, "/bit_err"},     64'(rxIf.bit_err),     64'd0);
  endtask

  task automatic checkEvents(input string tag);
    int n;
    checkOutput({tag, "/pvCount"}, 64'(actPv.size()), 64'(expPv.size()));
    n = (actPv.size() < expPv.size()) ? actPv.size() : expPv.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "/pvCycle"}, 64'(actPv[i].cyc),  64'(expPv[i].cyc));
      checkOutput({tag, "/pvData"},  64'(actPv[i].data), 64'(expPv[i].data));
      checkOutput({tag, "/pvIdx"},   64'(actPv[i].idx),  64'(expPv[i].idx));
    end
    checkOutput({tag, "/fdCount"}, 64'(actFd.size()), 64'(expFd.size()));
    n = (actFd.size() < expFd.size()) ? actFd.size() : expFd.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "/fdCycle"}, 64'(actFd[i].cyc), 64'(expFd[i].cyc));
      checkOutput({tag, "/fdLen"},   64'(actFd[i].len), 64'(expFd[i].len));
    end
    checkOutput({tag, "/errCount"}, 64'(actErr.size()), 64'(expErr.size()));
    n = (actErr.size() < expErr.size()) ? actErr.size() : expErr.size();
    for (int i = 0; i < n; i++)
      checkOutput({tag, "/errCycle"}, 64'(actErr[i]), 64'(expErr[i]));
    actPv.delete();
    expPv.delete();
    actFd.delete();
    expFd.delete();
    actErr.delete();
    expErr.delete();
  endtask

  initial begin
    logic [23:0] w;
    int          nPix;

    modelClear();
    lastFall = 0;
    doReset();
    repeat (3) begin
      @(posedge sys_clk);
      #1;
    end
    checkResetOutputs("reset");
    releaseReset();
    sendGap(2520);

    // Directed pixel with nominal bit timings.
    w = 24'hA53CF0;
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) sendBit(38, 24);
      else      sendBit(18, 44);
    end
    sendGap(2600);
    checkEvents("decode");

    // A pixel before the first reset gap must be ignored.
    doReset();
    releaseReset();
    sendGap(100);
    sendBits(24'($urandom), 24, 1'b0, 0);
    sendGap(2600);
    sendBits(24'($urandom), 24, 1'b0, 0);
    sendGap(2600);
    checkEvents("syncGate");

    // Boundary widths 5/27/28/60 with a 3-cycle glitch between bits.
    w = {4'b0011, 20'($urandom)};
    sendBit(MIN_HIGH, 10);
    sendBit(BIT_THRESH - 1, 10);
    sendBit(3, 10);
    sendBit(BIT_THRESH, 10);
    sendBit(MAX_HIGH, 10);
    sendBits(w, 20, 1'b0, 0);
    sendGap(2600);
    checkEvents("boundary");

    // Stuck-high line mid-pixel, then bits that must be ignored.
    sendBits(24'($urandom), 10, 1'b0, 0);
    sendBit(70, 10);
    sendBits(24'($urandom), 14, 1'b0, 0);
    sendGap(2600);
    sendBits(24'($urandom), 24, 1'b0, 0);
    sendGap(2600);
    checkEvents("stuckHigh");

    // Partial pixel followed by a reset gap.
    sendBits(24'($urandom), 12, 1'b0, 0);
    sendGap(2600);
    checkEvents("partial");

    // Random frames with glitches and an occasional trailing partial pixel.
    repeat (2) begin
      nPix = int'($urandom_range(3, 1));
      repeat (nPix) sendBits(24'($urandom), 24, 1'b0, 15);
      if ($urandom_range(1, 0) == 1) sendBits(24'($urandom), int'($urandom_range(5, 1)), 1'b0, 0);
      sendGap(2600);
    end
    checkEvents("random");

    // More pixels than a frame may report.
    repeat (PIXEL_MAX + 1) sendBits(24'($urandom), 24, 1'b1, 0);
    sendGap(2600);
    checkEvents("overflow");

    // Reset in the middle of a frame, then a clean frame after a gap.
    sendBits(24'($urandom), 24, 1'b1, 0);
    sendBits(24'($urandom), 6, 1'b1, 0);
    doReset();
    checkResetOutputs("midReset");
    releaseReset();
    checkEvents("midFrame");
    sendGap(2600);
    sendBits(24'($urandom), 24, 1'b1, 10);
    sendGap(2600);
    checkEvents("afterReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
